pwm_duty_capture: RTL and testbench

- Receive-side counterpart of the team's 14-bit PWM generator.
- Samples an asynchronous PWM input and measures the high time and the period of each complete cycle.
- Reports the duty word in the generator's encoding (high cycles = duty + 1), so a generator driving this block round-trips its duty value.
- Sits at board-level PWM inputs (servo/ESC feedback, loop-back self-test) ahead of control logic.

---
 rtl/pwm_duty_capture.sv | 163 ++++++++++++++++
 tb/tb_pwm_duty_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input, reporting duty as high cycles - 1.
// Optional 3-sample glitch filter enabled with `define PWM_CAPTURE_GLITCH_EN.
module pwm_duty_capture #(
  parameter int CNT_W       = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             clr,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_lvl
);

  typedef enum logic [1:0] {ST_SYNC, ST_HIGH, ST_LOW} state_e;

  localparam logic [CNT_W:0] PER_ONE = (CNT_W+1)'(1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s, lvl, lvl_prev, rise, fall, timeout;
  logic [CNT_W:0]         per_q, per_d, hi_q, hi_d, period_q, period_d, hi_m1;
  logic [CNT_W-1:0]       duty_q, duty_d, duty_meas;
  logic                   valid_q, valid_d, stuck_q, stuck_d, slvl_q, slvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_EN
  logic [1:0] hist_q;
  logic       filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], pwm_s};
      filt_q <= lvl;
    end
  end

  // filt_q is the delayed level; lvl is its next value, so an edge costs only two cycles
  assign lvl      = (pwm_s == hist_q[0] && pwm_s == hist_q[1]) ? pwm_s : filt_q;
  assign lvl_prev = filt_q;
`else
  logic pwm_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_d_q <= 1'b0;
    else        pwm_d_q <= pwm_s;
  end

  assign lvl      = pwm_s;
  assign lvl_prev = pwm_d_q;
`endif

  assign rise    = lvl & ~lvl_prev;
  assign fall    = ~lvl & lvl_prev;
  assign timeout = (per_q == '1);

  // High times above 2^CNT_W do not fit the duty word and saturate
  assign hi_m1     = hi_q - PER_ONE;
  assign duty_meas = hi_m1[CNT_W] ? '1 : hi_m1[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SYNC;
      per_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      slvl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      slvl_q   <= slvl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    slvl_d   = slvl_q;
    if (clr) begin
      state_d = ST_SYNC;
      per_d   = '0;
      hi_d    = '0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (rise) begin
            per_d   = PER_ONE;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (timeout) begin
            stuck_d = 1'b1;
            slvl_d  = lvl;
            duty_d  = {CNT_W{lvl}};
            valid_d = 1'b1;
            per_d   = '0;
            state_d = ST_SYNC;
          end else if (fall) begin
            hi_d    = per_q;
            per_d   = per_q + PER_ONE;
            state_d = ST_LOW;
          end else begin
            per_d = per_q + PER_ONE;
          end
        end
        ST_LOW: begin
          if (rise) begin
            period_d = per_q;
            duty_d   = duty_meas;
            valid_d  = 1'b1;
            per_d    = PER_ONE;
            stuck_d  = 1'b0;
            slvl_d   = 1'b0;
            state_d  = ST_HIGH;
          end else if (timeout) begin
            stuck_d = 1'b1;
            slvl_d  = lvl;
            duty_d  = {CNT_W{lvl}};
            valid_d = 1'b1;
            per_d   = '0;
            state_d = ST_SYNC;
          end else begin
            per_d = per_q + PER_ONE;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  assign duty      = duty_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign stuck     = stuck_q;
  assign stuck_lvl = slvl_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: segment-level model of the PWM waveform predicts every valid pulse.
// Narrow CNT_W keeps timeouts and full-scale periods short.
module tb_pwm_duty_capture;

  localparam int W    = 10;
  localparam int TO   = (1 << (W + 1)) - 1;
  localparam int DMAX = (1 << W) - 1;
`ifdef PWM_CAPTURE_GLITCH_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int MINSEG = FILT ? 3 : 1;
  localparam int M_SYNC = 0, M_HIGH = 1, M_LOW = 2;

  logic         clk = 1'b0, rst_n = 1'b0, pwm_in = 1'b0, clr = 1'b0;
  logic [W-1:0] duty;
  logic [W:0]   period;
  logic         valid, stuck, stuck_lvl;

  pwm_duty_capture #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .clr(clr),
    .duty(duty), .period(period), .valid(valid),
    .stuck(stuck), .stuck_lvl(stuck_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int period;
    bit stuck;
    bit lvl;
  } ev_t;

  ev_t exp_q[$], dut_q[$];
  ev_t mon_ev;
  int  n_chk = 0, n_pass = 0;

  int  m_st = M_SYNC, m_hi = 0, m_duty = 0, m_period = 0;
  bit  m_stuck = 1'b0;
  bit  cur_lvl = 1'b0;
  int  cur_len = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      mon_ev.duty   = int'(duty);
      mon_ev.period = int'(period);
      mon_ev.stuck  = stuck;
      mon_ev.lvl    = stuck_lvl;
      dut_q.push_back(mon_ev);
    end
  end

  function automatic void push_exp(bit st, bit l);
    ev_t e;
    e.duty = m_duty; e.period = m_period; e.stuck = st; e.lvl = l;
    exp_q.push_back(e);
  endfunction

  function automatic void m_timeout(bit l);
    m_stuck = 1'b1;
    m_duty  = l ? DMAX : 0;
    push_exp(1'b1, l);
    m_st = M_SYNC;
  endfunction

  // A completed low segment is always followed by a rising edge
  function automatic void m_complete(bit l, int len);
    if (l) begin
      if (m_st == M_HIGH) begin
        if (len >= TO) m_timeout(1'b1);
        else begin m_hi = len; m_st = M_LOW; end
      end
    end else begin
      if (m_st == M_LOW) begin
        if (m_hi + len > TO) m_timeout(1'b0);
        else begin
          m_period = m_hi + len;
          m_duty   = (m_hi > (1 << W)) ? DMAX : m_hi - 1;
          m_stuck  = 1'b0;
          push_exp(1'b0, 1'b0);
        end
      end
      m_st = M_HIGH;
    end
  endfunction

  function automatic void m_feed(bit l, int len);
    if (l == cur_lvl || (FILT && len < 3)) cur_len += len;
    else begin
      m_complete(cur_lvl, cur_len);
      cur_lvl = l;
      cur_len = len;
    end
  endfunction

  task automatic drive(input bit l, input int len);
    pwm_in = l;
    m_feed(l, len);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic drive_clr(input bit l, input int len, input int at);
    pwm_in = l;
    m_feed(l, len);
    repeat (at) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    m_st = M_SYNC;
    repeat (len - at - 1) @(posedge clk);
    #1;
  endtask

  task automatic checkpoint(input string tag);
    check_eq({tag, ".count"}, dut_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      check_eq($sformatf("%s[%0d].duty", tag, i), dut_q[i].duty, exp_q[i].duty);
      check_eq($sformatf("%s[%0d].period", tag, i), dut_q[i].period, exp_q[i].period);
      check_eq($sformatf("%s[%0d].stuck", tag, i), int'(dut_q[i].stuck), int'(exp_q[i].stuck));
      if (exp_q[i].stuck)
        check_eq($sformatf("%s[%0d].stuck_lvl", tag, i), int'(dut_q[i].lvl), int'(exp_q[i].lvl));
    end
    check_eq({tag, ".live_duty"}, int'(duty), m_duty);
    check_eq({tag, ".live_period"}, int'(period), m_period);
    check_eq({tag, ".live_stuck"}, int'(stuck), int'(m_stuck));
    dut_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int hi, lo;
    #1;
    check_eq("rst.duty", int'(duty), 0);
    check_eq("rst.period", int'(period), 0);
    check_eq("rst.valid", int'(valid), 0);
    check_eq("rst.stuck", int'(stuck), 0);
    check_eq("rst.stuck_lvl", int'(stuck_lvl), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    drive(1'b0, 20);
    repeat (4) begin drive(1'b1, 257); drive(1'b0, 767); end
    checkpoint("quarter");
    repeat (3) begin drive(1'b1, 1); drive(1'b0, 1023); end
    checkpoint("duty_min");
    repeat (3) begin drive(1'b1, 1023); drive(1'b0, 1); end
    drive(1'b1, 40);
    checkpoint("duty_max");

    drive(1'b0, 10); drive(1'b1, 1025); drive(1'b0, 100);
    drive(1'b1, 1024); drive(1'b0, 100); drive(1'b1, 20);
    checkpoint("saturate");

    drive(1'b0, 50); drive(1'b1, 2500); drive(1'b0, 30);
    checkpoint("stuck_hi");
    drive(1'b1, 300); drive(1'b0, 700); drive(1'b1, 20);
    checkpoint("recover_hi");
    drive(1'b0, 2500); drive(1'b1, 30);
    checkpoint("stuck_lo");
    drive(1'b0, 500); drive(1'b1, 100);
    checkpoint("recover_lo");

    drive(1'b0, 400); drive_clr(1'b1, 600, 300);
    drive(1'b0, 400); drive(1'b1, 20);
    checkpoint("clr_hold");
    drive(1'b0, 200); drive(1'b1, 20);
    checkpoint("clr_after");

    drive(1'b0, 700); drive(1'b1, 100); drive(1'b0, 2); drive(1'b1, 155);
    drive(1'b0, 767); drive(1'b1, 20);
    checkpoint("glitch");

    drive(1'b0, 100);
    checkpoint("pre_rst");
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid.duty", int'(duty), 0);
    check_eq("rst_mid.period", int'(period), 0);
    check_eq("rst_mid.valid", int'(valid), 0);
    check_eq("rst_mid.stuck", int'(stuck), 0);
    check_eq("rst_mid.stuck_lvl", int'(stuck_lvl), 0);
    m_st = M_SYNC; m_duty = 0; m_period = 0; m_stuck = 1'b0;
    cur_lvl = 1'b0; cur_len = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 10); drive(1'b1, 200); drive(1'b0, 300);
    checkpoint("rst_first");
    drive(1'b1, 20);
    checkpoint("rst_second");

    for (int i = 0; i < 40; i++) begin
      hi = ($urandom_range(99, 0) < 8) ? 2100 : int'($urandom_range(1100, MINSEG));
      lo = ($urandom_range(99, 0) < 8) ? 2100 : int'($urandom_range(600, MINSEG));
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
    drive(1'b1, 30);
    checkpoint("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
